pkt_mbst_monitor: RTL and testbench



---
 rtl/pkt_mbst_pkg.sv | 22 ++
 rtl/pkt_mbst_chan.sv | 119 +++++++++++
 rtl/pkt_mbst_monitor.sv | 60 ++++++
 tb/tb_pkt_mbst_monitor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_mbst_pkg.sv
// Shared definitions for the multi-channel packet burst monitor.
package pkt_mbst_pkg;

  localparam int unsigned NUM_ERR          = 6;
  localparam int unsigned ERR_SOP_GAP      = 0;
  localparam int unsigned ERR_SOP_SOP      = 1;
  localparam int unsigned ERR_EOP_EOP      = 2;
  localparam int unsigned ERR_EOP_NO_VALID = 3;
  localparam int unsigned ERR_VALID_IDLE   = 4;
  localparam int unsigned ERR_LEN_OVF      = 5;

  // Gap counter width covers the full MIN_SOP_GAP range (2..255).
  localparam int unsigned GAP_W = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_e;

  typedef logic [NUM_ERR-1:0] err_vec_t;

endpackage

// File: rtl/pkt_mbst_chan.sv
// One monitored channel: delimiter FSM, SOP gap and beat tracking,
// error pulses/sticky bits and saturating packet/error counters.
module pkt_mbst_chan
  import pkt_mbst_pkg::*;
#(
  parameter int unsigned MIN_SOP_GAP   = 8,
  parameter int unsigned MAX_PKT_BEATS = 2048,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sop,
  input  logic                 eop,
  input  logic                 valid,
  input  logic                 zero,
  input  logic                 clr,
  output err_vec_t             err_pulse,
  output err_vec_t             err_sticky,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int unsigned      BEAT_W   = $clog2(MAX_PKT_BEATS + 2);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_PKT_BEATS);
  localparam logic [BEAT_W-1:0] BEAT_SAT = BEAT_W'(MAX_PKT_BEATS + 1);
  localparam logic [GAP_W-1:0]  GAP_MIN  = GAP_W'(MIN_SOP_GAP);

  state_e               state_q, state_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  err_vec_t             err_c;
  logic                 pkt_inc_c;
  logic                 gap_armed_c;
  logic [CNT_WIDTH-1:0] pkt_base_c, err_base_c;

  // A gap count of zero means no non-zero SOP seen since reset.
  assign gap_armed_c = (gap_q != '0) && (gap_q < GAP_MIN);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    err_c     = '0;
    pkt_inc_c = 1'b0;

    err_c[ERR_SOP_GAP]      = sop & gap_armed_c;
    err_c[ERR_EOP_NO_VALID] = eop & ~valid;

    if (sop && !zero) begin
      gap_d = GAP_W'(1);
    end else if (gap_armed_c) begin
      gap_d = gap_q + GAP_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        err_c[ERR_VALID_IDLE] = valid & ~sop;
        if (sop && eop) begin
          pkt_inc_c = 1'b1;
        end else if (sop) begin
          state_d = ST_IN_PKT;
          beat_d  = BEAT_W'(1);
        end else if (eop) begin
          err_c[ERR_EOP_EOP] = 1'b1;
        end
      end
      ST_IN_PKT: begin
        if (sop) begin
          err_c[ERR_SOP_SOP] = 1'b1;
          if (eop) begin
            state_d = ST_IDLE;
          end else begin
            beat_d = BEAT_W'(1);
          end
        end else begin
          // Overflow fires once when the count steps past the limit, then holds.
          if (valid) begin
            if (beat_q == BEAT_MAX) begin
              err_c[ERR_LEN_OVF] = 1'b1;
              beat_d             = BEAT_SAT;
            end else if (beat_q < BEAT_MAX) begin
              beat_d = beat_q + BEAT_W'(1);
            end
          end
          if (eop) begin
            state_d   = ST_IDLE;
            pkt_inc_c = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear acts first so a same-cycle event survives it.
  assign pkt_base_c = clr ? '0 : pkt_cnt;
  assign err_base_c = clr ? '0 : err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      beat_q     <= '0;
      err_pulse  <= '0;
      err_sticky <= '0;
      pkt_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      beat_q     <= beat_d;
      err_pulse  <= err_c;
      err_sticky <= (clr ? '0 : err_sticky) | err_c;
      pkt_cnt    <= (pkt_inc_c && !(&pkt_base_c)) ? pkt_base_c + CNT_WIDTH'(1) : pkt_base_c;
      err_cnt    <= ((|err_c) && !(&err_base_c)) ? err_base_c + CNT_WIDTH'(1) : err_base_c;
    end
  end

endmodule

// File: rtl/pkt_mbst_monitor.sv
// Passive multi-channel packet delimiter monitor with per-channel error
// status and a single maskable interrupt.
module pkt_mbst_monitor
  import pkt_mbst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned MIN_SOP_GAP   = 8,
  parameter int unsigned MAX_PKT_BEATS = 2048,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  data,
  input  logic [NUM_CH-1:0]             sop,
  input  logic [NUM_CH-1:0]             eop,
  input  logic [NUM_CH-1:0]             valid,
  input  logic [NUM_CH-1:0]             zero,
  input  logic                          clr,
  input  logic [NUM_CH*NUM_ERR-1:0]     err_mask,
  output logic [NUM_CH*NUM_ERR-1:0]     err_pulse,
  output logic [NUM_CH*NUM_ERR-1:0]     err_sticky,
  output logic [NUM_CH*CNT_WIDTH-1:0]   pkt_cnt,
  output logic [NUM_CH*CNT_WIDTH-1:0]   err_cnt,
  output logic                          irq
);

  // Payload is carried for bus compatibility only.
  logic unused_data;
  assign unused_data = ^data;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pkt_mbst_chan #(
      .MIN_SOP_GAP   (MIN_SOP_GAP),
      .MAX_PKT_BEATS (MAX_PKT_BEATS),
      .CNT_WIDTH     (CNT_WIDTH)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .sop        (sop[c]),
      .eop        (eop[c]),
      .valid      (valid[c]),
      .zero       (zero[c]),
      .clr        (clr),
      .err_pulse  (err_pulse[c*NUM_ERR +: NUM_ERR]),
      .err_sticky (err_sticky[c*NUM_ERR +: NUM_ERR]),
      .pkt_cnt    (pkt_cnt[c*CNT_WIDTH +: CNT_WIDTH]),
      .err_cnt    (err_cnt[c*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(err_sticky & err_mask);
    end
  end

endmodule

// File: tb/tb_pkt_mbst_monitor.sv
// Directed and randomized checks of pkt_mbst_monitor against a cycle-level
// behavioural model of the delimiter rules.
module tb_pkt_mbst_monitor;
  import pkt_mbst_pkg::*;

  localparam int unsigned DW   = 64;
  localparam int unsigned NCH  = 4;
  localparam int unsigned GAP  = 8;
  localparam int unsigned MAXB = 16;
  localparam int unsigned CW   = 8;
  localparam int unsigned EW   = NCH * NUM_ERR;
  localparam int          CMAX = (1 << CW) - 1;

  logic              clk;
  logic              rst_n;
  logic [NCH*DW-1:0] data;
  logic [NCH-1:0]    sop, eop, valid, zero;
  logic              clr;
  logic [EW-1:0]     err_mask;
  logic [EW-1:0]     err_pulse, err_sticky;
  logic [NCH*CW-1:0] pkt_cnt, err_cnt;
  logic              irq;

  pkt_mbst_monitor #(
    .DATA_WIDTH    (DW),
    .NUM_CH        (NCH),
    .MIN_SOP_GAP   (GAP),
    .MAX_PKT_BEATS (MAXB),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .sop        (sop),
    .eop        (eop),
    .valid      (valid),
    .zero       (zero),
    .clr        (clr),
    .err_mask   (err_mask),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt),
    .irq        (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Reference model state, one entry per channel.
  bit            m_in_pkt [NCH];
  int            m_beats  [NCH];
  int            m_last   [NCH];
  int            m_pkt    [NCH];
  int            m_err    [NCH];
  logic [EW-1:0] m_sticky;
  logic [EW-1:0] m_pulse;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_in_pkt[c] = 1'b0;
      m_beats[c]  = 0;
      m_last[c]   = -1;
      m_pkt[c]    = 0;
      m_err[c]    = 0;
    end
    m_sticky = '0;
    m_pulse  = '0;
  endtask

  // Predict this cycle's effect, clock it, then compare every output.
  task automatic step();
    logic              exp_irq;
    logic [EW-1:0]     pv;
    logic [NCH*CW-1:0] exp_pkt, exp_err;
    exp_irq = |(m_sticky & err_mask);
    if (clr) begin
      m_sticky = '0;
      for (int c = 0; c < NCH; c++) begin
        m_pkt[c] = 0;
        m_err[c] = 0;
      end
    end
    pv = '0;
    for (int c = 0; c < NCH; c++) begin
      bit s, e, v, z;
      logic [NUM_ERR-1:0] ev;
      bit done;
      s = sop[c]; e = eop[c]; v = valid[c]; z = zero[c];
      ev   = '0;
      done = 1'b0;
      if (s && m_last[c] >= 0 && (cyc - m_last[c]) < GAP) ev[ERR_SOP_GAP] = 1'b1;
      if (e && !v) ev[ERR_EOP_NO_VALID] = 1'b1;
      if (!m_in_pkt[c]) begin
        if (v && !s) ev[ERR_VALID_IDLE] = 1'b1;
        if (s && e) done = 1'b1;
        else if (s) begin m_in_pkt[c] = 1'b1; m_beats[c] = 1; end
        else if (e) ev[ERR_EOP_EOP] = 1'b1;
      end else if (s) begin
        ev[ERR_SOP_SOP] = 1'b1;
        if (e) m_in_pkt[c] = 1'b0;
        else m_beats[c] = 1;
      end else begin
        if (v) begin
          m_beats[c]++;
          if (m_beats[c] == MAXB + 1) ev[ERR_LEN_OVF] = 1'b1;
        end
        if (e) begin m_in_pkt[c] = 1'b0; done = 1'b1; end
      end
      if (s && !z) m_last[c] = cyc;
      if (done && m_pkt[c] < CMAX) m_pkt[c]++;
      if (ev != '0 && m_err[c] < CMAX) m_err[c]++;
      pv[c*NUM_ERR +: NUM_ERR] = ev;
    end
    m_pulse  = pv;
    m_sticky = m_sticky | pv;
    for (int c = 0; c < NCH; c++) begin
      exp_pkt[c*CW +: CW] = CW'(m_pkt[c]);
      exp_err[c*CW +: CW] = CW'(m_err[c]);
    end
    @(posedge clk);
    #1;
    cyc++;
    check("err_pulse",  64'(err_pulse),  64'(m_pulse));
    check("err_sticky", 64'(err_sticky), 64'(m_sticky));
    check("pkt_cnt",    64'(pkt_cnt),    64'(exp_pkt));
    check("err_cnt",    64'(err_cnt),    64'(exp_err));
    check("irq",        64'(irq),        64'(exp_irq));
  endtask

  task automatic drv(input int c, input bit s, input bit e, input bit v, input bit z);
    sop = '0; eop = '0; valid = '0; zero = '0;
    sop[c] = s; eop[c] = e; valid[c] = v; zero[c] = z;
    step();
  endtask

  task automatic idle(input int n);
    sop = '0; eop = '0; valid = '0; zero = '0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    sop = '0; eop = '0; valid = '0; zero = '0; clr = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst_pulse",  64'(err_pulse),  64'(0));
    check("rst_sticky", 64'(err_sticky), 64'(0));
    check("rst_pkt",    64'(pkt_cnt),    64'(0));
    check("rst_err",    64'(err_cnt),    64'(0));
    check("rst_irq",    64'(irq),        64'(0));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    data = '0; clr = 1'b0; err_mask = '0;
    sop = '0; eop = '0; valid = '0; zero = '0;
    do_reset();

    // Two back-to-back packets on channel 0.
    drv(0, 1, 0, 1, 0);
    repeat (9) drv(0, 0, 0, 1, 0);
    drv(0, 0, 1, 1, 0);
    check("t1_pkt_first", 64'(pkt_cnt[0 +: CW]), 64'(1));
    drv(0, 1, 1, 1, 0);
    check("t1_pkt_second", 64'(pkt_cnt[0 +: CW]), 64'(2));
    check("t1_no_errors", 64'(err_cnt), 64'(0));

    // SOP gap: violated at 5 cycles, clean at exactly MIN_SOP_GAP.
    drv(1, 1, 1, 1, 0);
    idle(4);
    drv(1, 1, 1, 1, 0);
    check("t2_gap_short", 64'(err_pulse[1*NUM_ERR + ERR_SOP_GAP]), 64'(1));
    idle(10);
    drv(1, 1, 1, 1, 0);
    idle(7);
    drv(1, 1, 1, 1, 0);
    check("t2_gap_exact", 64'(err_pulse[1*NUM_ERR +: NUM_ERR]), 64'(0));

    // SOP inside a packet restarts it.
    drv(3, 1, 0, 1, 0);
    repeat (8) drv(3, 0, 0, 1, 0);
    drv(3, 1, 0, 1, 0);
    check("t3_sop_sop", 64'(err_pulse[3*NUM_ERR + ERR_SOP_SOP]), 64'(1));
    check("t3_err_cnt", 64'(err_cnt[3*CW +: CW]), 64'(1));
    drv(3, 0, 1, 1, 0);
    check("t3_pkt_cnt", 64'(pkt_cnt[3*CW +: CW]), 64'(1));

    // EOP without valid still closes the packet; stray valid afterwards.
    drv(0, 1, 0, 1, 0);
    drv(0, 0, 0, 1, 0);
    drv(0, 0, 1, 0, 0);
    check("t4_eop_no_valid", 64'(err_pulse[0*NUM_ERR + ERR_EOP_NO_VALID]), 64'(1));
    drv(0, 0, 0, 1, 0);
    check("t4_valid_idle", 64'(err_pulse[0*NUM_ERR + ERR_VALID_IDLE]), 64'(1));

    // Length overflow on channel 2 with its interrupt enabled.
    err_mask[2*NUM_ERR + ERR_LEN_OVF] = 1'b1;
    drv(2, 1, 0, 1, 0);
    repeat (15) drv(2, 0, 0, 1, 0);
    check("t5_len_at_max", 64'(err_pulse[2*NUM_ERR + ERR_LEN_OVF]), 64'(0));
    drv(2, 0, 0, 1, 0);
    check("t5_len_ovf", 64'(err_pulse[2*NUM_ERR + ERR_LEN_OVF]), 64'(1));
    drv(2, 0, 0, 1, 0);
    check("t5_len_once", 64'(err_pulse[2*NUM_ERR + ERR_LEN_OVF]), 64'(0));
    check("t5_irq", 64'(irq), 64'(1));
    drv(2, 0, 1, 1, 0);

    // Clear coinciding with a SOP gap violation.
    drv(2, 1, 1, 1, 0);
    idle(1);
    clr = 1'b1;
    drv(2, 1, 1, 1, 0);
    clr = 1'b0;
    check("t6_sticky", 64'(err_sticky), 64'(1) << (2*NUM_ERR + ERR_SOP_GAP));
    check("t6_err_cnt", 64'(err_cnt[2*CW +: CW]), 64'(1));
    idle(2);
    check("t6_irq_off", 64'(irq), 64'(0));

    // Reset mid-packet: next EOP is judged from IDLE.
    drv(1, 1, 0, 1, 0);
    drv(1, 0, 0, 1, 0);
    do_reset();
    drv(1, 0, 1, 1, 0);
    check("t7_eop_eop", 64'(err_pulse[1*NUM_ERR + ERR_EOP_EOP]), 64'(1));
    check("t7_pkt_cnt", 64'(pkt_cnt[1*CW +: CW]), 64'(0));

    // Randomized traffic, including counter saturation.
    for (int i = 0; i < 1500; i++) begin
      if ((i % 100) == 0) err_mask = EW'($urandom);
      clr = ($urandom_range(0, 63) == 0);
      for (int c = 0; c < NCH; c++) begin
        valid[c] = ($urandom_range(0, 9) < 7);
        sop[c]   = ($urandom_range(0, 9) == 0);
        eop[c]   = ($urandom_range(0, 9) == 0);
        zero[c]  = ($urandom_range(0, 4) == 0);
        data[c*DW +: DW] = {$urandom, $urandom};
      end
      step();
    end
    clr = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
